muldiv_seq: RTL and testbench

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/mips_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 144 ++++++++++++++
 tb/tb_muldiv_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: HI/LO unit op encoding, its FSM states, and small helpers.
// Core decode uses the same op encoding when it issues multiply/divide.
package mips_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic op_is_div(input md_op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input md_op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // Two's-complement magnitude for signed ops; raw value for unsigned ones.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} accumulator: shift-add for multiply,
// restoring shift-subtract (one quotient bit into lo[0]) for divide.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opnd_i,
  output logic [2*W-1:0] acc_o
);

  logic [W-1:0] a_hi;
  logic [W-1:0] a_lo;
  logic [W:0]   sum;
  logic [W:0]   shifted;
  logic [W-1:0] rem;
  logic         ge;

  assign a_hi = acc_i[2*W-1:W];
  assign a_lo = acc_i[W-1:0];

  always_comb begin
    sum     = {1'b0, a_hi} + (a_lo[0] ? {1'b0, opnd_i} : '0);
    shifted = {a_hi, a_lo[W-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    // Partial remainder stays below the divisor, so the difference fits in W bits.
    rem     = shifted[W-1:0] - opnd_i;
    if (is_div) begin
      acc_o = ge ? {rem, a_lo[W-2:0], 1'b1} : {shifted[W-1:0], a_lo[W-2:0], 1'b0};
    end else begin
      acc_o = {sum, a_lo[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MIPS HI/LO multiply/divide unit: 32 radix-2 steps, then a sign-fix cycle.
// Owns the FSM, iteration counter and HI/LO; busy/stall feed the pipeline hazard logic.
module muldiv_seq
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              hilo_rd,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] STEPS = 6'(DATA_W);

  md_state_e           state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic                div_q, div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                done_q, done_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opnd_q, opnd_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  md_op_e              op_e;
  logic                op_signed;
  logic                op_div;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [2*DATA_W-1:0] step_acc;
  logic [2*DATA_W-1:0] prod_fix;

  assign op_e      = md_op_e'(op);
  assign op_signed = op_is_signed(op_e);
  assign op_div    = op_is_div(op_e);
  assign rs_mag    = mag(rs_val, op_signed);
  assign rt_mag    = mag(rt_val, op_signed);
  assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

  muldiv_step #(.W(DATA_W)) u_step (
    .is_div (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          div_d = op_div;
          cnt_d = '0;
          if (op_div && (rt_val == '0)) begin
            // Divide by zero skips iteration; FIX copies the accumulator out unchanged.
            acc_d    = {rs_val, {DATA_W{1'b1}}};
            neg_lo_d = 1'b0;
            neg_hi_d = 1'b0;
            state_d  = MD_FIX;
          end else begin
            acc_d    = op_div ? {{DATA_W{1'b0}}, rs_mag} : {{DATA_W{1'b0}}, rt_mag};
            opnd_d   = op_div ? rt_mag : rs_mag;
            neg_lo_d = op_signed & (rs_val[DATA_W-1] ^ rt_val[DATA_W-1]);
            neg_hi_d = op_signed & op_div & rs_val[DATA_W-1];
            state_d  = MD_RUN;
          end
        end
      end
      MD_RUN: begin
        // The edge after the last step only hands over to FIX.
        if (cnt_q == STEPS) begin
          state_d = MD_FIX;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 6'd1;
        end
      end
      MD_FIX: begin
        if (div_q) begin
          lo_d = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
          hi_d = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        end else begin
          lo_d = prod_fix[DATA_W-1:0];
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q != MD_IDLE);
  assign stall = (hilo_rd & busy) | (start & busy);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed vector table, random ops against an arithmetic
// reference, plus stall/ignored-start and mid-operation reset sequences.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hilo_rd = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  muldiv_seq #(.DATA_W(32)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .hilo_rd (hilo_rd),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates and % follows the dividend.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
      default: begin
        if (b == 0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb;
          rl = q[31:0]; rh = r[31:0];
        end else begin
          rl = a / b; rh = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return $urandom_range(0, 20);
      1: return 32'h0;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and wait for done; lat = edges from the start edge, bcyc = busy cycles.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl,
                        output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    bcyc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    rh = hi;
    rl = lo;
    $display("op=%0d rs=%08h rt=%08h -> hi=%08h lo=%08h lat=%0d busy=%0d", o, a, b, rh, rl, lat, bcyc);
  endtask

  initial begin
    logic [31:0] rh, rl, eh, el, h1, l1;
    int lat, bcyc;
    logic [1:0] o;
    logic [31:0] a, b;
    logic saw_done;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        34};
    vecs[4]  = '{2'b11, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34};
    vecs[6]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
    vecs[7]  = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         34};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         34};
    vecs[9]  = '{2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1};
    vecs[10] = '{2'b01, 32'h0,         32'h1234,      32'h0,         32'h0,         34};
    vecs[11] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 34};
    vecs[12] = '{2'b11, 32'd5,         32'hFFFF_FFFF, 32'd5,         32'h0,         34};

    // Reset with a start request present: the request must be discarded.
    start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1; start = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    chk("reset_start_dropped", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, rh, rl, lat, bcyc);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcyc), 64'(vecs[i].lat));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("vec%0d_hold_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      ref_op(o, a, b, eh, el);
      run_op(o, a, b, rh, rl, lat, bcyc);
      chk($sformatf("rnd%0d_hi", i), 64'(rh), 64'(eh));
      chk($sformatf("rnd%0d_lo", i), 64'(rl), 64'(el));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), (o[1] && b == 0) ? 64'd1 : 64'd34);
    end

    // MULT with MFHI/MFLO waiting from cycle 5 and a second start at cycle 10.
    ref_op(2'b00, 32'h1234_5678, 32'hFFFF_FFFB, h1, l1);
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_val = 32'h1234_5678; rt_val = 32'hFFFF_FFFB;
    @(posedge clk);
    saw_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 5) hilo_rd = 1'b1;
      if (c == 10) begin
        start = 1'b1; op = 2'b11; rs_val = 32'd1; rt_val = 32'd1;
      end
      #1;
      if (c <= 34) begin
        chk($sformatf("stall_c%0d", c), 64'(stall), (c >= 5 || c == 10) ? 64'd1 : 64'd0);
      end else if (c == 35) begin
        chk("done_c35", 64'(done), 64'd1);
        chk("stall_done_cycle", 64'(stall), 64'd0);
        chk("mult_hi", 64'(hi), 64'(h1));
        chk("mult_lo", 64'(lo), 64'(l1));
        hilo_rd = 1'b0;
      end else begin
        if (done) saw_done = 1'b1;
        chk($sformatf("idle_c%0d", c), 64'(busy), 64'd0);
      end
    end
    chk("second_start_no_done", 64'(saw_done), 64'd0);
    chk("mult_hi_kept", 64'(hi), 64'(h1));
    chk("mult_lo_kept", 64'(lo), 64'(l1));
    $display("stall sequence: mult hi=%08h lo=%08h", hi, lo);

    // Reset in the middle of a DIV.
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk);
    saw_done = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) nrst = 1'b0;
      if (c == 11) begin
        nrst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
      end
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("midrst_no_done", 64'(saw_done), 64'd0);
    $display("reset sequence: busy=%0d hi=%08h lo=%08h", busy, hi, lo);
    run_op(2'b11, 32'd100, 32'd7, rh, rl, lat, bcyc);
    chk("post_rst_hi", 64'(rh), 64'd2);
    chk("post_rst_lo", 64'(rl), 64'd14);
    chk("post_rst_lat", 64'(lat), 64'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
